// File: rtl/mem_arbiter.sv
// Byte-serial owner of the RAM/IO port: arbitrates fetch vs. load/store and
// splits each granted access into byte transfers, assembling reads little-endian.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] wdata;
        logic [2:0]  n;
        logic        is_if;
    } xfer_t;

    function automatic logic [2:0] size_to_n(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    state_t          state, state_nxt;
    xfer_t           req, req_nxt;
    logic [2:0]      iss, iss_nxt;
    logic [2:0]      cap, cap_nxt;
    logic            cap_vld, cap_vld_nxt;
    logic [3:0][7:0] rbuf, rbuf_nxt;
    logic [31:0]     if_data_nxt, mem_rdata_nxt;

    always_comb begin
        state_nxt     = state;
        req_nxt       = req;
        iss_nxt       = iss;
        cap_nxt       = cap;
        cap_vld_nxt   = 1'b0;
        rbuf_nxt      = rbuf;
        if_data_nxt   = if_data;
        mem_rdata_nxt = mem_rdata;
        ram_a         = 32'd0;
        ram_dout      = 8'd0;
        ram_wr        = 1'b0;
        if_done       = 1'b0;
        mem_done      = 1'b0;

        case (state)
            IDLE: begin
                if (rdy) begin
                    if (mem_req) begin
                        req_nxt.base  = mem_addr;
                        req_nxt.wdata = mem_wdata;
                        req_nxt.n     = size_to_n(mem_size);
                        req_nxt.is_if = 1'b0;
                        iss_nxt       = 3'd0;
                        cap_nxt       = 3'd0;
                        rbuf_nxt      = '0;
                        state_nxt     = mem_we ? MEM_WR : MEM_RD;
                    end else if (if_req && !if_flush) begin
                        req_nxt.base  = if_addr;
                        req_nxt.wdata = 32'd0;
                        req_nxt.n     = 3'd4;
                        req_nxt.is_if = 1'b1;
                        iss_nxt       = 3'd0;
                        cap_nxt       = 3'd0;
                        rbuf_nxt      = '0;
                        state_nxt     = IF_RD;
                    end
                end
            end

            IF_RD, MEM_RD: begin
                // Present the awaited byte's address whenever nothing new is issued,
                // so the bus never runs ahead of n (no speculative IO reads).
                ram_a = req.base + {29'd0, cap};
                if (state == IF_RD && if_flush) begin
                    state_nxt = IDLE;
                end else if (!rdy) begin
                    // Anything issued but not yet captured is reissued on resume.
                    iss_nxt = cap;
                end else begin
                    if (iss < req.n) begin
                        ram_a       = req.base + {29'd0, iss};
                        iss_nxt     = iss + 3'd1;
                        cap_vld_nxt = 1'b1;
                    end
                    if (cap_vld) begin
                        rbuf_nxt[cap[1:0]] = ram_din;
                        cap_nxt            = cap + 3'd1;
                        if (cap + 3'd1 == req.n) begin
                            state_nxt = DONE;
                            if (req.is_if) if_data_nxt = rbuf_nxt;
                            else           mem_rdata_nxt = rbuf_nxt;
                        end
                    end
                end
            end

            MEM_WR: begin
                ram_a    = req.base + {29'd0, iss};
                ram_dout = req.wdata[{iss[1:0], 3'b000} +: 8];
                if (rdy) begin
                    ram_wr  = 1'b1;
                    iss_nxt = iss + 3'd1;
                    if (iss + 3'd1 == req.n) state_nxt = DONE;
                end
            end

            DONE: begin
                // A flush landing on the done cycle still kills the fetch result.
                if_done   = req.is_if && !if_flush;
                mem_done  = !req.is_if;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req       <= '0;
            iss       <= 3'd0;
            cap       <= 3'd0;
            cap_vld   <= 1'b0;
            rbuf      <= '0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            state     <= state_nxt;
            req       <= req_nxt;
            iss       <= iss_nxt;
            cap       <= cap_nxt;
            cap_vld   <= cap_vld_nxt;
            rbuf      <= rbuf_nxt;
            if_data   <= if_data_nxt;
            mem_rdata <= mem_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM model with one-cycle read latency,
// expected completions queued at request time and checked when done pulses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_flush = 1'b0;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = 8'd0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [15:0] a, input int n);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = pat(a + 16'(i));
        return w;
    endfunction

    // Byte RAM: registered read, write on ram_wr; preloaded on the first edge.
    logic [7:0] ram [0:65535];
    bit ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= pat(16'(i));
            ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h05;
            ram[16'h0102] <= 8'h00; ram[16'h0103] <= 8'h00;
            ram[16'h2003] <= 8'hA7;
            ram[16'h0500] <= 8'h11; ram[16'h0501] <= 8'h22;
            ram[16'h0502] <= 8'h33; ram[16'h0503] <= 8'h44;
            ram_init <= 1'b1;
        end else begin
            ram_din <= ram[ram_a[15:0]];
            if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
        end
    end

    typedef struct {
        logic [31:0] data;
        int          lo;
        int          hi;
    } exp_t;
    exp_t sb[$];

    int n_asrt = 0;
    int n_fail = 0;
    logic [31:0] tr_a  [0:31];
    logic        tr_wr [0:31];
    logic [7:0]  tr_do [0:31];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input int lo, input int hi);
        exp_t e;
        e.data = d; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    // Cycle k starts at the edge after the call; inputs change 1 time unit after
    // each edge, outputs are sampled on the falling edge.
    task automatic run(input bit want_if, input int pf, input int pl, input int fl,
                       input int budget, output int kd);
        kd = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            rdy = !(k >= pf && k < pf + pl);
            if (k == fl) begin
                if_flush = 1'b1;
                if_req   = 1'b0;
            end else begin
                if_flush = 1'b0;
            end
            @(negedge clk);
            tr_a[k] = ram_a; tr_wr[k] = ram_wr; tr_do[k] = ram_dout;
            if (want_if ? if_done : mem_done) begin
                kd = k;
                break;
            end
        end
    endtask

    task automatic check_txn(input string tag, input bit want_if, input int kd);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            if (e.lo == e.hi) chk({tag, "_lat"}, kd, e.lo);
            else chk({tag, "_lat_rng"}, {31'd0, kd >= e.lo && kd <= e.hi}, 32'd1);
            chk({tag, "_data"}, want_if ? if_data : mem_rdata, e.data);
        end
    endtask

    task automatic drop_reqs();
        @(posedge clk); #1;
        if_req  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        @(negedge clk);
        chk("idle_ram_a", ram_a, 32'd0);
        chk("idle_dones", {30'd0, if_done, mem_done}, 32'd0);
    endtask

    task automatic start_mem(input bit we, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = we; mem_addr = a; mem_size = sz; mem_wdata = wd;
    endtask

    task automatic start_if(input logic [31:0] a);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a;
    endtask

    initial begin
        int kd;
        bit bad;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ctl", {28'd0, ram_wr, if_done, mem_done, 1'b0}, 32'd0);
        chk("rst_dout", {24'd0, ram_dout}, 32'd0);
        chk("rst_data", if_data | mem_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Word fetch
        start_if(32'h100);
        push(32'h00000513, 5, 5);
        run(1'b1, 0, 0, -1, 12, kd);
        check_txn("fetch", 1'b1, kd);
        for (int i = 0; i < 4; i++) chk("fetch_addr", tr_a[i], 32'h100 + i);
        drop_reqs();

        // Simultaneous requests: load byte wins, fetch follows
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2003; mem_size = 2'b00;
        push(32'h000000A7, 2, 2);
        push(exp_rd(16'h200, 4), 5, 5);
        run(1'b0, 0, 0, -1, 12, kd);
        check_txn("lb", 1'b0, kd);
        chk("lb_addr", tr_a[0], 32'h2003);
        @(posedge clk); #1 mem_req = 1'b0;
        @(negedge clk);
        chk("lb_idle", ram_a, 32'd0);
        run(1'b1, 0, 0, -1, 12, kd);
        check_txn("fetch2", 1'b1, kd);
        chk("fetch2_addr", tr_a[0], 32'h200);
        drop_reqs();

        // Word store
        start_mem(1'b1, 32'h1000, 2'b10, 32'hDEADBEEF);
        push(32'h000000A7, 4, 4);
        run(1'b0, 0, 0, -1, 12, kd);
        chk("sw_lat", kd, 4);
        chk("sw_rdata_hold", mem_rdata, sb.pop_front().data);
        for (int i = 0; i < 4; i++) begin
            chk("sw_wr", {31'd0, tr_wr[i]}, 32'd1);
            chk("sw_addr", tr_a[i], 32'h1000 + i);
        end
        chk("sw_dout", {tr_do[3], tr_do[2], tr_do[1], tr_do[0]}, 32'hDEADBEEF);
        chk("sw_done_nowr", {31'd0, tr_wr[4]}, 32'd0);
        drop_reqs();

        // Read back stored word, then an upper halfword (zero-extended)
        start_mem(1'b0, 32'h1000, 2'b10, 32'd0);
        push(32'hDEADBEEF, 5, 5);
        run(1'b0, 0, 0, -1, 12, kd);
        check_txn("lw", 1'b0, kd);
        drop_reqs();
        start_mem(1'b0, 32'h1002, 2'b01, 32'd0);
        push(32'h0000DEAD, 3, 3);
        run(1'b0, 0, 0, -1, 12, kd);
        check_txn("lh", 1'b0, kd);
        drop_reqs();

        // Flush in cycle 2 of a fetch, then fetch at the branch target
        start_if(32'h300);
        run(1'b1, 0, 0, 2, 4, kd);
        chk("flush_no_done", kd, -1);
        chk("flush_idle", tr_a[3], 32'd0);
        chk("flush_data_hold", if_data, exp_rd(16'h200, 4));
        start_if(32'h400);
        push(exp_rd(16'h400, 4), 5, 5);
        run(1'b1, 0, 0, -1, 12, kd);
        check_txn("target", 1'b1, kd);
        drop_reqs();

        // Flush landing on the done cycle suppresses if_done
        start_if(32'h600);
        run(1'b1, 0, 0, 5, 7, kd);
        chk("flush_done_no_done", kd, -1);
        chk("flush_done_idle", tr_a[6], 32'd0);

        // Three pause cycles from cycle 2 of a word load
        start_mem(1'b0, 32'h500, 2'b10, 32'd0);
        push(32'h44332211, 8, 9);
        run(1'b0, 2, 3, -1, 20, kd);
        check_txn("pause", 1'b0, kd);
        for (int i = 2; i < 5; i++) begin
            chk("pause_wr", {31'd0, tr_wr[i]}, 32'd0);
            chk("pause_addr", tr_a[i], 32'h501);
        end
        drop_reqs();

        // IO-range byte load: bus never leaves the one requested address
        start_mem(1'b0, 32'h30001, 2'b00, 32'd0);
        push(exp_rd(16'h0001, 1), 2, 2);
        run(1'b0, 0, 0, -1, 12, kd);
        check_txn("io", 1'b0, kd);
        bad = 1'b0;
        for (int k = 0; k <= kd && k < 32; k++) if (tr_a[k] > 32'h30001) bad = 1'b1;
        chk("io_no_spec", {31'd0, bad}, 32'd0);
        drop_reqs();

        // Reset in the middle of a store, then a fresh fetch
        start_mem(1'b1, 32'h1800, 2'b10, 32'h01020304);
        run(1'b0, 0, 0, -1, 2, kd);
        chk("rstw_wr_before", {31'd0, tr_wr[1]}, 32'd1);
        #1 rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        #1;
        chk("rstw_ctl", {29'd0, ram_wr, if_done, mem_done}, 32'd0);
        chk("rstw_bus", ram_a | {24'd0, ram_dout}, 32'd0);
        chk("rstw_data", if_data | mem_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        push(32'h00000513, 5, 5);
        run(1'b1, 0, 0, -1, 12, kd);
        check_txn("post_rst", 1'b1, kd);
        drop_reqs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sole owner of the CPU's byte-wide RAM/IO port. It arbitrates between the instruction-fetch requester and the load/store requester from the MEM stage, and serializes each granted access into byte transfers at consecutive addresses. Read data is assembled little-endian. Instruction fetches can be aborted by a branch flush. The block sits between the fetch/MEM stages and the top-level memory bus.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous and active-low (0 = reset)
- rdy  in  1  global ready; low = pause
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address, word-aligned, stable while if_req
- if_flush  in  1  branch interception; aborts a fetch
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched instruction
- mem_req  in  1  load/store request, level, held until mem_done
- mem_we  in  1  1 = store
- mem_addr  in  32  byte address
- mem_size  in  2  00 = byte, 01 = half, 10 = word (11 treated as word)
- mem_wdata  in  32  store data; byte 0 is written first
- mem_done  out  1  one-cycle pulse; mem_rdata valid for loads
- mem_rdata  out  32  load data, zero-extended (sign extension is done in MEM)
- ram_din  in  8  bus read data
- ram_dout  out  8  bus write data
- ram_a  out  32  bus address
- ram_wr  out  1  1 = write

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Counters (3 bits each): n = byte count; iss = bytes issued; cap = bytes captured.
- IDLE arbitration:
  - mem_req wins over if_req.
  - if_req with if_flush high is not granted.
  - On grant, latch addr, size, wdata and requester; clear iss and cap.
  - Next state is MEM_WR, MEM_RD or IF_RD.
- Byte count n: 1, 2 or 4 from mem_size; n = 4 for fetches.
- Read states:
  - Each active cycle with iss < n: drive ram_a = base + iss, then iss++.
  - Each active cycle after an issue cycle that was itself active: capture ram_din into byte lane cap, then cap++.
  - When cap reaches n, go to DONE.
- MEM_WR: each active cycle drives ram_a = base + iss, ram_dout = wdata byte iss, ram_wr = 1, then iss++. When iss reaches n, go to DONE.
- DONE: pulse the granted requester's done for one cycle, then go to IDLE.
  - No arbitration happens in DONE; requesters drop req on the edge that ends DONE.
- Data outputs: mem_rdata and if_data hold their last value until the next completion. Unread upper bytes are 0.
- Flush:
  - if_flush high in IF_RD or IF-owned DONE: next state IDLE, and if_done is suppressed (gated combinationally in DONE).
  - if_flush is ignored for MEM transactions.
- Pause (rdy = 0):
  - Freeze state and counters. ram_wr = 0. No capture.
  - In read states ram_a = base + cap, so ram_din carries the awaited byte in the first resumed cycle.
  - A byte issued in the cycle just before the pause is reissued after resume.
- Idle outputs: ram_a = 0, ram_wr = 0, ram_dout = 0.
- Addresses ≥ 0x30000 (IO) are handled identically. Bytes are never issued beyond n, so no speculative IO reads occur.
- Reset (asynchronous, any state): state IDLE, counters 0, all outputs 0, in-flight access dropped.

## Timing
- Grant edge G is the edge where IDLE samples req; cycle k is the k-th cycle after G.
- Reads of n bytes:
  - Addresses are driven in cycles 0..n-1.
  - Byte k is captured at the end of cycle k+1.
  - done is asserted in cycle n+1.
  - A word fetch therefore pulses if_done in cycle 5. IDLE returns in cycle 6, and the earliest next grant is the edge ending cycle 6.
- Writes of n bytes: ram_wr = 1 in cycles 0..n-1; mem_done in cycle n.
- Each pause cycle adds exactly one cycle of latency. For reads, a pause may add one more cycle for the reissue.
- done outputs are registered, apart from the if_flush gate.

## Test plan
- Word fetch at 0x100 with bytes 13 05 00 00 → ram_a = 0x100..0x103 in cycles 0-3; if_done in cycle 5 with if_data = 0x00000513.
- if_req and mem_req (lb at 0x2003) rise together → mem served first. mem_done in cycle 2 with mem_rdata = 0x000000xx. The fetch is granted on the edge ending cycle 3.
- sw 0xDEADBEEF to 0x1000 → ram_wr = 1 for 4 cycles; ram_dout EF, BE, AD, DE at 0x1000..0x1003; mem_done in cycle 4.
- if_flush asserted in cycle 2 of a fetch → IDLE next cycle, no if_done; a new fetch at the branch target completes normally.
- rdy low for 3 cycles starting in cycle 2 of a word load → ram_wr stays 0 and ram_a = base + cap during the pause; returned data matches memory; done is delayed 3-4 cycles.
- rst driven low mid-MEM_WR → ram_wr drops immediately, all outputs 0; after release, a fresh fetch completes in 6 cycles.
